// File: rtl/mac_result_checker.sv
// Compares a stream of fp32 MAC results against golden values with a ULP tolerance,
// keeps a readable capture of every DUT result and reports run statistics.
`timescale 1ns/1ps
module mac_result_checker #(
  parameter int DEPTH = 1000,
  parameter int TOL   = 0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        EN,
  input  logic [10:0] cnt,
  input  logic        in_valid,
  input  logic [31:0] dut_mac,
  input  logic [31:0] exp_mac,
  input  logic [9:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] n_checked,
  output logic [10:0] err_cnt,
  output logic [10:0] first_err_idx,
  output logic [31:0] first_err_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [10:0]        LAST_MAX = 11'(DEPTH - 1);
  localparam logic [10:0]        NO_ERR   = 11'h7FF;
  localparam logic signed [33:0] TOL_W    = 34'(TOL);

  state_t       state_q;
  logic [10:0]  idx_q, last_q;
  logic [10:0]  n_q, err_q, fidx_q;
  logic [31:0]  fgot_q, rd_q;
  logic         busy_q, done_q, pass_q;

  logic         vld_p1, fin_p1;
  logic [31:0]  dut_p1, exp_p1;
  logic [10:0]  idx_p1;

  logic [31:0]  mem [DEPTH];

  logic         accept, hit;
  logic [10:0]  err_sat, last_d;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Negative values fold below zero so ordinal distance equals ULP distance across the sign.
  function automatic logic signed [33:0] ordinal(input logic [31:0] v);
    logic signed [33:0] mag;
    mag = {3'b000, v[30:0]};
    return v[31] ? -mag : mag;
  endfunction

  function automatic logic mac_match(input logic [31:0] a, input logic [31:0] b);
    logic signed [33:0] diff;
    if (is_nan(a) && is_nan(b)) return 1'b1;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b1;
    diff = ordinal(a) - ordinal(b);
    if (diff < 0) diff = -diff;
    return diff <= TOL_W;
  endfunction

  assign accept  = !rst && (state_q == S_RUN) && in_valid && (idx_q <= last_q);
  assign hit     = mac_match(dut_p1, exp_p1);
  assign err_sat = (err_q == NO_ERR) ? err_q : err_q + 11'd1;
  assign last_d  = (cnt > LAST_MAX) ? LAST_MAX : cnt;

  // Stage 1: capture write and pair registration
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[idx_q[9:0]] <= dut_mac;
      dut_p1          <= dut_mac;
      exp_p1          <= exp_mac;
      idx_p1          <= idx_q;
    end
  end

  // Stage 2: apply comparison result and sequence the run
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      n_q     <= '0;
      err_q   <= '0;
      fidx_q  <= NO_ERR;
      fgot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      vld_p1  <= 1'b0;
      fin_p1  <= 1'b0;
    end else begin
      vld_p1 <= accept;
      fin_p1 <= accept && (idx_q == last_q);
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (EN) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            last_q  <= last_d;
            n_q     <= '0;
            err_q   <= '0;
            fidx_q  <= NO_ERR;
            fgot_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) idx_q <= idx_q + 11'd1;
          if (vld_p1) begin
            n_q <= n_q + 11'd1;
            if (!hit) begin
              err_q <= err_sat;
              if (err_q == '0) begin
                fidx_q <= idx_p1;
                fgot_q <= dut_p1;
              end
            end
            if (fin_p1) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= hit && (err_q == '0);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Readback port: registered, old data on same-cycle write
  always_ff @(posedge CLK) begin
    if (rst) begin
      rd_q <= '0;
    end else if (int'(rd_addr) < DEPTH) begin
      rd_q <= mem[rd_addr];
    end else begin
      rd_q <= '0;
    end
  end

  assign rd_data       = rd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign n_checked     = n_q;
  assign err_cnt       = err_q;
  assign first_err_idx = fidx_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_mac_result_checker.sv
// Directed bench for mac_result_checker: vectors are queued as driven and the
// run summary is checked against an independent fp32 ULP model when done rises.
`timescale 1ns/1ps
module tb_mac_result_checker;

  logic        CLK = 1'b0;
  logic        rst, EN, in_valid;
  logic [10:0] cnt;
  logic [31:0] dut_mac, exp_mac;
  logic [9:0]  rd_addr;

  logic [31:0] rd_data, first_err_got, rd_data1, first_err_got1;
  logic        busy, done, pass, busy1, done1, pass1;
  logic [10:0] n_checked, err_cnt, first_err_idx, n_checked1, err_cnt1, first_err_idx1;

  always #5 CLK = ~CLK;

  mac_result_checker #(.DEPTH(1000), .TOL(0)) u0 (
    .CLK(CLK), .rst(rst), .EN(EN), .cnt(cnt), .in_valid(in_valid),
    .dut_mac(dut_mac), .exp_mac(exp_mac), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .n_checked(n_checked), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_got(first_err_got));

  mac_result_checker #(.DEPTH(1000), .TOL(1)) u1 (
    .CLK(CLK), .rst(rst), .EN(EN), .cnt(cnt), .in_valid(in_valid),
    .dut_mac(dut_mac), .exp_mac(exp_mac), .rd_addr(rd_addr), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .pass(pass1), .n_checked(n_checked1), .err_cnt(err_cnt1),
    .first_err_idx(first_err_idx1), .first_err_got(first_err_got1));

  typedef struct { logic [31:0] d; logic [31:0] e; } vec_t;
  vec_t        sb[$];
  logic [31:0] mem_m [1024];
  bit          m_run;
  int          m_idx, m_last;
  int          n_asserts = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  function automatic bit m_match(input logic [31:0] d, input logic [31:0] e, input int tol);
    longint od, oe, df;
    if (m_nan(d) && m_nan(e)) return 1'b1;
    if (d[30:0] == 0 && e[30:0] == 0) return 1'b1;
    od = longint'(d[30:0]);
    oe = longint'(e[30:0]);
    if (d[31]) od = -od;
    if (e[31]) oe = -oe;
    df = od - oe;
    if (df < 0) df = -df;
    return df <= longint'(tol);
  endfunction

  task automatic start_run(input int c);
    cnt = 11'(c);
    EN  = 1'b1;
    tick();
    EN  = 1'b0;
    m_run  = 1'b1;
    m_idx  = 0;
    m_last = (c > 999) ? 999 : c;
    sb.delete();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_nchk", 32'(n_checked), 32'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] e);
    dut_mac  = d;
    exp_mac  = e;
    in_valid = 1'b1;
    if (m_run && m_idx <= m_last) begin
      sb.push_back('{d, e});
      mem_m[m_idx] = d;
      m_idx++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic verify_summary(input string tag);
    int n, err0, err1, fidx;
    logic [31:0] fgot;
    vec_t v;
    n = 0; err0 = 0; err1 = 0; fidx = 2047; fgot = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      if (!m_match(v.d, v.e, 0)) begin
        if (err0 == 0) begin fidx = n; fgot = v.d; end
        err0++;
      end
      if (!m_match(v.d, v.e, 1)) err1++;
      n++;
    end
    m_run = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_nchk"}, 32'(n_checked), 32'(n));
    chk({tag, "_err"}, 32'(err_cnt), 32'(err0));
    chk({tag, "_fidx"}, 32'(first_err_idx), 32'(fidx));
    chk({tag, "_fgot"}, first_err_got, fgot);
    chk({tag, "_pass"}, 32'(pass), 32'(err0 == 0));
    chk({tag, "_pass_tol1"}, 32'(pass1), 32'(err1 == 0));
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    tick();
    verify_summary(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_nchk"}, 32'(n_checked), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
    chk({tag, "_fidx"}, 32'(first_err_idx), 32'd2047);
    chk({tag, "_fgot"}, first_err_got, 32'd0);
    chk({tag, "_rd"}, rd_data, 32'd0);
  endtask

  task automatic readback(input string tag, input int a, input logic [31:0] exp);
    rd_addr = 10'(a);
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    logic [31:0] r, old0;
    rst = 1'b1; EN = 1'b0; cnt = '0; in_valid = 1'b0;
    dut_mac = '0; exp_mac = '0; rd_addr = '0;
    m_run = 1'b0; m_idx = 0; m_last = 0;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    send(32'h1, 32'h2);
    chk("idle_ignore_nchk", 32'(n_checked), 32'd0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // all-match run of 10
    start_run(9);
    for (int i = 0; i < 10; i++) begin
      r = $urandom();
      send(r, r);
      if (i == 4) chk("pass_in_run", 32'(pass), 32'd0);
    end
    check_done("t_match");
    chk("t_match_n10", 32'(n_checked), 32'd10);

    // one-ULP error at vector 2; cnt/EN wiggled mid-run must be ignored
    start_run(4);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cnt = 11'd0; EN = 1'b1;
        send(32'h3F800001, 32'h3F800000);
        EN = 1'b0;
      end else begin
        r = $urandom() & 32'h3FFFFFFF;
        send(r, r);
      end
    end
    check_done("t_ulp");
    chk("t_ulp_fidx_const", 32'(first_err_idx), 32'd2);
    chk("t_ulp_fgot_const", first_err_got, 32'h3F800001);
    chk("t_ulp_tol1_pass_const", 32'(pass1), 32'd1);

    // signed zero, NaN pair, opposite infinities
    start_run(2);
    send(32'h80000000, 32'h00000000);
    send(32'h7FC00000, 32'h7F800001);
    send(32'h7F800000, 32'hFF800000);
    check_done("t_special");
    chk("t_special_err_const", 32'(err_cnt), 32'd1);
    chk("t_special_fidx_const", 32'(first_err_idx), 32'd2);

    // valid gaps, plus same-cycle readback returning old data
    start_run(2);
    old0 = mem_m[0];
    rd_addr = 10'd0;
    send(32'h40000000, 32'h40000000);
    chk("rd_old_data", rd_data, old0);
    tick(); tick();
    send(32'h40400000, 32'h40400000);
    send(32'hC0800000, 32'hC0800000);
    check_done("t_gap");
    readback("t_gap_rd1", 1, mem_m[1]);
    chk("t_gap_rd1_const", rd_data, 32'h40400000);

    // clamp cnt=1500 to 1000 vectors; extra valids ignored
    start_run(1500);
    for (int i = 0; i < 1000; i++) begin
      r = $urandom() & 32'h3FFFFFFF;
      if (i == 500) send(r + 32'd1, r);
      else send(r, r);
    end
    chk("t_clamp_done_early", 32'(done), 32'd0);
    send(32'h12345678, 32'h0);
    verify_summary("t_clamp");
    chk("t_clamp_n1000", 32'(n_checked), 32'd1000);
    send(32'h0BADF00D, 32'h0);
    chk("t_clamp_after_done", 32'(n_checked), 32'd1000);
    readback("t_clamp_rd999", 999, mem_m[999]);
    readback("t_clamp_rd1000", 1000, 32'd0);
    readback("t_clamp_rd1023", 1023, 32'd0);

    // reset mid-run, with EN and in_valid also high at the reset edge
    start_run(9);
    for (int i = 0; i < 3; i++) send(32'h41000000 + 32'(i), 32'h41000000 + 32'(i));
    rst = 1'b1; EN = 1'b1; in_valid = 1'b1; dut_mac = 32'hDEADBEEF;
    tick();
    rst = 1'b0; EN = 1'b0; in_valid = 1'b0;
    m_run = 1'b0; sb.delete();
    chk_reset("mid_rst");
    for (int a = 0; a < 4; a++) readback($sformatf("mid_rst_rd%0d", a), a, mem_m[a]);
    start_run(3);
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      send(r, r);
    end
    check_done("t_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
